// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the store write buffer.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned SWB_DEPTH   = 4;
  // One buffered store is {address, data}.
  localparam int unsigned SWB_ENTRY_W = 2 * XLEN;

endpackage

// File: rtl/swb_fifo_ctrl.sv
// Store write buffer control: head/tail pointers, occupancy count,
// full/empty, and push/pop qualification. Full and empty come from the
// count only; pointers wrap naturally at DEPTH (a power of two).
module swb_fifo_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = SWB_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_req,
  input  logic             i_coalesce,
  input  logic             i_mem_ready,
  output logic [PTR_W-1:0] o_head,
  output logic [PTR_W-1:0] o_tail,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_push,
  output logic             o_stall
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_stall;
  logic             w_push;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & i_mem_ready;
  // A full buffer that drains this cycle, or a store that merges into the
  // youngest entry, still takes the store.
  assign w_stall = i_wr_req & w_full & ~i_mem_ready & ~i_coalesce;
  // Only a non-merging store allocates a new slot.
  assign w_push  = i_wr_req & ~w_stall & ~i_coalesce;

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_push  = w_push;
  assign o_stall = w_stall;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the single-cycle core and the data-memory port.
// Queues core stores and drains them in program order over valid/ready.
// Optional build macro STORE_COALESCE_EN: a store to the youngest entry's
// address (with at least two entries queued) overwrites that entry's data.
module store_write_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH  = SWB_DEPTH,
  parameter int unsigned ADDR_W = XLEN,
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] RD2_Top,
  output logic              Stall,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [PTR_W-1:0]  w_head;
  logic [PTR_W-1:0]  w_tail;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_push;
  logic              w_stall;
  logic              w_coalesce;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0]  w_youngest;
  assign w_youngest = w_tail - PTR_W'(1);
  // count>=2 keeps the entry on the memory port untouched.
  assign w_coalesce = MemWrite & (w_count >= CNT_W'(2)) &
                      (r_addr[w_youngest] == ALUResult);
`else
  assign w_coalesce = 1'b0;
`endif

  swb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_wr_req    (MemWrite),
    .i_coalesce  (w_coalesce),
    .i_mem_ready (mem_ready),
    .o_head      (w_head),
    .o_tail      (w_tail),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_push      (w_push),
    .o_stall     (w_stall)
  );

  // Entry storage: allocate at tail, or merge data into the youngest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[w_tail] <= ALUResult;
        r_data[w_tail] <= RD2_Top;
      end
`ifdef STORE_COALESCE_EN
      else if (w_coalesce) begin
        r_data[w_youngest] <= RD2_Top;
      end
`endif
    end
  end

  // Memory port reads the head entry straight from storage.
  assign mem_valid = ~w_empty;
  assign mem_addr  = r_addr[w_head];
  assign mem_wdata = r_data[w_head];
  assign Stall     = w_stall;
  assign count     = w_count;
  assign empty     = w_empty;

endmodule
